// File: rtl/circular_buffer_controller_pkg.sv
// Shared state encoding and occupancy-width helper for the circular-buffer controller.
package circular_buffer_controller_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Occupancy must be able to represent DEPTH itself, hence depth+1 codes.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEPTH_DFLT = 8;
  localparam int CW_DFLT    = count_width(DEPTH_DFLT);

endpackage

// File: rtl/circular_buffer_controller_occupancy_tracker.sv
// Occupancy register: adds PAR_WRITE per push, subtracts PAR_READ per pop, both in one cycle.
// One-cycle update; no backpressure of its own, callers guarantee no overrun/underrun.
module occupancy_tracker
  import circular_buffer_controller_pkg::*;
#(
  parameter int PAR_WRITE = 1,
  parameter int PAR_READ  = 1,
  parameter int DEPTH     = DEPTH_DFLT,
  parameter int CW        = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic [CW-1:0] count
);

  localparam logic [CW:0] INC = (CW+1)'(PAR_WRITE);
  localparam logic [CW:0] DEC = (CW+1)'(PAR_READ);

  // One extra bit keeps the intermediate sum exact before truncation.
  logic [CW:0] count_ext;
  assign count_ext = ({1'b0, count} + (push ? INC : '0)) - (pop ? DEC : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= CW'(count_ext);
    end
  end

endmodule

// File: rtl/circular_buffer_controller.sv
// Flow controller turning valid/ready beats into wen/cnt_w/cnt_r; zero-latency strobes, registered state.
// Write/read readiness follows word occupancy so wide beats never overrun/underrun; flush drains whole read beats.
module circular_buffer_controller
  import circular_buffer_controller_pkg::*;
#(
  parameter int PAR_WRITE = 1,
  parameter int PAR_READ  = 1,
  parameter int DEPTH     = DEPTH_DFLT,
  parameter int CW        = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          rd_valid,
  input  logic          rd_ready,
  input  logic          flush,
  input  logic          dp_full,
  input  logic          dp_empty,
  output logic          wen,
  output logic          cnt_w,
  output logic          cnt_r,
  output logic [CW-1:0] count,
  output logic          flush_done,
  output logic          err
);

  localparam logic [CW-1:0] PW = CW'(PAR_WRITE);
  localparam logic [CW-1:0] PR = CW'(PAR_READ);
  localparam logic [CW-1:0] DP = CW'(DEPTH);

  state_t state;
  logic   push;
  logic   pop;
  logic   mismatch;

  assign wr_ready = (state == RUN) && ((DP - count) >= PW);
  assign rd_valid = (state == RUN) && (count >= PR);

  assign push  = wr_valid && wr_ready;
  assign pop   = (rd_valid && rd_ready) || ((state == FLUSH) && (count >= PR));
  assign wen   = push;
  assign cnt_w = push;
  assign cnt_r = pop;

  assign mismatch = ((count == '0) != dp_empty) || ((count == DP) && !dp_full);

  occupancy_tracker #(
    .PAR_WRITE (PAR_WRITE),
    .PAR_READ  (PAR_READ),
    .DEPTH     (DEPTH),
    .CW        (CW)
  ) u_occupancy (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      flush_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        INIT:    state <= RUN;
        RUN:     if (flush) state <= FLUSH;
        FLUSH: begin
          // A sub-beat residue cannot be popped; it stays counted.
          if (count < PR) begin
            state      <= RUN;
            flush_done <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
      if ((state != INIT) && mismatch) begin
        err <= 1'b1;
      end
    end
  end

endmodule
